// File: rtl/fifo_ctrl_occ_if.sv
// rtl/fifo_ctrl_occ_if.sv - user request / RAM control bundle for the FIFO pointer controller
interface fifo_ctrl_occ_if #(
  parameter int ADDR_W = 4
);
  logic              read;
  logic              write;
  logic              clr_err;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] writeAddr;
  logic [ADDR_W-1:0] readAddr;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output read, write, clr_err,
    input  wr_en, rd_en, writeAddr, readAddr, count,
    input  empty, full, almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  read, write, clr_err,
    output wr_en, rd_en, writeAddr, readAddr, count,
    output empty, full, almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl_occ.sv
// rtl/fifo_ctrl_occ.sv - full-capacity FIFO pointer/flag controller with occupancy and sticky errors
module fifo_ctrl_occ #(
  parameter int ADDR_W = 4,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2
) (
  input  logic clk,
  input  logic reset,
  fifo_ctrl_occ_if.slave bus
);
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_C    = AF_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_LVL[ADDR_W:0];

  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            empty_q, full_q, almost_empty_q, almost_full_q;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            wr_acc, rd_acc;

  assign wr_acc = bus.write & ~full_q;
  assign rd_acc = bus.read & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ONE_C;
    if (rd_acc) rd_ptr_d = rd_ptr_q + ONE_C;
    if (wr_acc & ~rd_acc) begin
      count_d = count_q + ONE_C;
    end else if (rd_acc & ~wr_acc) begin
      count_d = count_q - ONE_C;
    end
    // A new error on this edge outranks a simultaneous clear.
    overflow_d  = (bus.write & full_q) | (overflow_q & ~bus.clr_err);
    underflow_d = (bus.read & empty_q) | (underflow_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= (count_d == '0);
      full_q         <= (count_d == DEPTH_C);
      almost_empty_q <= (count_d <= AE_C);
      almost_full_q  <= (count_d >= AF_C);
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  assign bus.wr_en        = wr_acc;
  assign bus.rd_en        = rd_acc;
  assign bus.writeAddr    = wr_ptr_q[ADDR_W-1:0];
  assign bus.readAddr     = rd_ptr_q[ADDR_W-1:0];
  assign bus.count        = count_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl_occ.sv
// tb/tb_fifo_ctrl_occ.sv - directed self-checking bench for fifo_ctrl_occ
module tb_fifo_ctrl_occ;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  fifo_ctrl_occ_if #(.ADDR_W(4)) bus ();

  fifo_ctrl_occ #(.ADDR_W(4), .AF_LVL(14), .AE_LVL(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic c);
    bus.read    = r;
    bus.write   = w;
    bus.clr_err = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_waddr"}, int'(bus.writeAddr), 0);
    check_eq({tag, "_raddr"}, int'(bus.readAddr), 0);
    check_eq({tag, "_count"}, int'(bus.count), 0);
    check_eq({tag, "_empty"}, int'(bus.empty), 1);
    check_eq({tag, "_aempty"}, int'(bus.almost_empty), 1);
    check_eq({tag, "_full"}, int'(bus.full), 0);
    check_eq({tag, "_afull"}, int'(bus.almost_full), 0);
    check_eq({tag, "_ovf"}, int'(bus.overflow), 0);
    check_eq({tag, "_unf"}, int'(bus.underflow), 0);
  endtask

  initial begin
    int ew;
    int er;
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    #11;
    check_reset_state("rst");
    reset = 1'b0;
    tick();
    check_reset_state("idle");

    // Fill to capacity, then one write too many.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      check_eq("fill_wr_en", int'(bus.wr_en), 1);
      tick();
      check_eq("fill_count", int'(bus.count), i);
      check_eq("fill_waddr", int'(bus.writeAddr), i % 16);
      check_eq("fill_afull", int'(bus.almost_full), (i >= 14) ? 1 : 0);
      check_eq("fill_full", int'(bus.full), (i == 16) ? 1 : 0);
      check_eq("fill_aempty", int'(bus.almost_empty), (i <= 2) ? 1 : 0);
    end
    drive(1'b0, 1'b1, 1'b0);
    check_eq("ovf_wr_en", int'(bus.wr_en), 0);
    tick();
    check_eq("ovf_count", int'(bus.count), 16);
    check_eq("ovf_waddr", int'(bus.writeAddr), 0);
    check_eq("ovf_flag", int'(bus.overflow), 1);

    // Simultaneous read/write while full, then while partially filled.
    drive(1'b1, 1'b1, 1'b0);
    check_eq("rwfull_wr_en", int'(bus.wr_en), 0);
    check_eq("rwfull_rd_en", int'(bus.rd_en), 1);
    tick();
    check_eq("rwfull_count", int'(bus.count), 15);
    check_eq("rwfull_raddr", int'(bus.readAddr), 1);
    check_eq("rwfull_waddr", int'(bus.writeAddr), 0);
    check_eq("rwfull_full", int'(bus.full), 0);
    check_eq("rwfull_ovf", int'(bus.overflow), 1);
    drive(1'b1, 1'b1, 1'b0);
    check_eq("rw15_wr_en", int'(bus.wr_en), 1);
    check_eq("rw15_rd_en", int'(bus.rd_en), 1);
    tick();
    check_eq("rw15_count", int'(bus.count), 15);
    check_eq("rw15_raddr", int'(bus.readAddr), 2);
    check_eq("rw15_waddr", int'(bus.writeAddr), 1);
    check_eq("rw15_afull", int'(bus.almost_full), 1);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    check_eq("clr_ovf", int'(bus.overflow), 0);

    // Return to empty via reset at a point away from the clock edge.
    drive(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_reset_state("rst2");
    #1 reset = 1'b0;
    tick();

    // Underflow behaviour and clear/set priority.
    drive(1'b1, 1'b0, 1'b0);
    check_eq("unf_rd_en", int'(bus.rd_en), 0);
    tick();
    check_eq("unf_count", int'(bus.count), 0);
    check_eq("unf_raddr", int'(bus.readAddr), 0);
    check_eq("unf_flag", int'(bus.underflow), 1);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    check_eq("unf_clr", int'(bus.underflow), 0);
    drive(1'b1, 1'b0, 1'b1);
    tick();
    check_eq("unf_set_wins", int'(bus.underflow), 1);
    drive(1'b0, 1'b0, 1'b1);
    tick();
    check_eq("unf_clr2", int'(bus.underflow), 0);
    drive(1'b1, 1'b1, 1'b0);
    check_eq("rwempty_wr_en", int'(bus.wr_en), 1);
    check_eq("rwempty_rd_en", int'(bus.rd_en), 0);
    tick();
    check_eq("rwempty_count", int'(bus.count), 1);
    check_eq("rwempty_empty", int'(bus.empty), 0);
    check_eq("rwempty_unf", int'(bus.underflow), 1);
    check_eq("rwempty_waddr", int'(bus.writeAddr), 1);
    check_eq("rwempty_raddr", int'(bus.readAddr), 0);
    drive(1'b1, 1'b0, 1'b1);
    tick();
    check_eq("drain1_count", int'(bus.count), 0);
    check_eq("drain1_empty", int'(bus.empty), 1);
    check_eq("drain1_unf", int'(bus.underflow), 0);

    // Fill 5 / drain 5 for 4 rounds, pointers start at 1 and wrap past 15.
    ew = 1;
    er = 1;
    cnt = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) begin
        drive(1'b0, 1'b1, 1'b0);
        tick();
        ew = (ew + 1) % 16;
        cnt++;
        check_eq("rnd_wcount", int'(bus.count), cnt);
        check_eq("rnd_waddr", int'(bus.writeAddr), ew);
        check_eq("rnd_waempty", int'(bus.almost_empty), (cnt <= 2) ? 1 : 0);
      end
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, 1'b0, 1'b0);
        tick();
        er = (er + 1) % 16;
        cnt--;
        check_eq("rnd_rcount", int'(bus.count), cnt);
        check_eq("rnd_raddr", int'(bus.readAddr), er);
        check_eq("rnd_raempty", int'(bus.almost_empty), (cnt <= 2) ? 1 : 0);
      end
      check_eq("rnd_empty", int'(bus.empty), 1);
    end
    check_eq("rnd_final_waddr", int'(bus.writeAddr), 5);

    // Mid-stream asynchronous reset with 9 words stored.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    check_eq("pre_rst_count", int'(bus.count), 9);
    drive(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_reset_state("rst3");
    #1 reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    check_eq("post_rst_wr_en", int'(bus.wr_en), 1);
    check_eq("post_rst_waddr", int'(bus.writeAddr), 0);
    tick();
    check_eq("post_rst_waddr_adv", int'(bus.writeAddr), 1);
    check_eq("post_rst_count", int'(bus.count), 1);
    drive(1'b0, 1'b0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
